// File: rtl/write_image.sv
// write_image: accepts packed pixel words over valid/ready and unpacks them one pixel per cycle
// into an image buffer with a registered read port. Macro WRITE_IMAGE_CHECKSUM_EN adds a 16-bit pixel checksum.
module write_image #(
  parameter int PIX_W        = 8,
  parameter int PIX_PER_WORD = 8,
  parameter int IMG_PIXELS   = 16,
  parameter int ADDR_W       = $clog2(IMG_PIXELS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [PIX_W*PIX_PER_WORD-1:0]   in_data,
  input  logic [ADDR_W-1:0]               rd_addr,
  output logic [PIX_W-1:0]                rd_data,
  output logic                            busy,
  output logic                            done
`ifdef WRITE_IMAGE_CHECKSUM_EN
  ,
  output logic [15:0]                     checksum
`endif
);
  localparam int WORD_W = PIX_W * PIX_PER_WORD;
  localparam int CNT_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int DEPTH  = 1 << ADDR_W;

  if (IMG_PIXELS <= 0 || (IMG_PIXELS % PIX_PER_WORD) != 0 || IMG_PIXELS > DEPTH) begin : g_bad_cfg
    $error("write_image: IMG_PIXELS must be a nonzero multiple of PIX_PER_WORD addressable by ADDR_W");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    UNPACK = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   shift_q, shift_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, busy_q, done_q;
  logic [PIX_W-1:0]    rd_data_q;
  logic [PIX_W-1:0]    mem_q [DEPTH];
  logic                wr_en_s, last_pix_s, frame_end_s;

  assign last_pix_s  = (cnt_q == CNT_W'(PIX_PER_WORD - 1));
  // Compare one bit wider so a power-of-two frame size cannot alias to zero.
  assign frame_end_s = (({1'b0, wr_ptr_q} + (ADDR_W+1)'(1)) == (ADDR_W+1)'(IMG_PIXELS));

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = LOAD;
          wr_ptr_d = '0;
        end else begin
          state_d  = state_q;
        end
      end
      LOAD: begin
        if (in_valid && in_ready_q) begin
          shift_d = in_data;
          cnt_d   = '0;
          state_d = UNPACK;
        end else begin
          state_d = LOAD;
        end
      end
      UNPACK: begin
        wr_en_s  = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        shift_d  = shift_q >> PIX_W;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_pix_s) begin
          state_d = frame_end_s ? DONE : LOAD;
        end else begin
          state_d = UNPACK;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      in_ready_q <= (state_d == LOAD);
      busy_q     <= (state_d == LOAD) || (state_d == UNPACK);
      done_q     <= (state_d == DONE);
    end
  end

  // Buffer write port; contents survive reset, and a reset cycle blocks the write.
  always_ff @(posedge clk) begin
    if (wr_en_s && !rst) begin
      mem_q[wr_ptr_q] <= shift_q[PIX_W-1:0];
    end
  end

  // Registered read port; addresses past the frame read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if ({1'b0, rd_addr} < (ADDR_W+1)'(IMG_PIXELS)) begin
      rd_data_q <= mem_q[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

`ifdef WRITE_IMAGE_CHECKSUM_EN
  logic [15:0] checksum_q, checksum_d;

  // Running sum of written pixels, restarted by an accepted start.
  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == IDLE || state_q == DONE) && start) begin
      checksum_d = 16'd0;
    end else if (wr_en_s) begin
      checksum_d = checksum_q + 16'(shift_q[PIX_W-1:0]);
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum_q <= 16'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;

endmodule

// File: doc/write_image.md
Name: write_image

Overview:
- Receiving end of the image word path: accepts 64-bit words, each packing 8 pixels, from the decode side over a valid/ready handshake.
- Unpacks each word one pixel per cycle into an on-chip image buffer.
- Exposes a registered read port so the reconstructed image can be dumped or compared against the source image.
- Signals completion once the whole image frame has been written.

Parameters:
- PIX_W, 8, bits per pixel.
- PIX_PER_WORD, 8, pixels packed per input word. Word width is PIX_W*PIX_PER_WORD (64).
- IMG_PIXELS, 16, pixels per frame. Must be a nonzero multiple of PIX_PER_WORD; this is an elaboration-time check.
- ADDR_W, $clog2(IMG_PIXELS), buffer address width (4).

Ports:
- clk  in  1  Clock.
- rst  in  1  Reset. Synchronous, active-high.
- start  in  1  Single-cycle pulse that begins frame capture.
- in_valid  in  1  Input word valid.
- in_ready  out  1  Block can accept a word this cycle.
- in_data  in  PIX_W*PIX_PER_WORD  Packed pixels. Pixel k is in bits [PIX_W*k+PIX_W-1 : PIX_W*k]; pixel 0 is in the LSBs.
- rd_addr  in  ADDR_W  Buffer read address.
- rd_data  out  PIX_W  Registered read data.
- busy  out  1  Frame capture in progress.
- done  out  1  Frame complete; held until the next start or reset.

Behaviour:
- Reset values: state IDLE; in_ready=0, busy=0, done=0, rd_data=0, write pointer=0, unpack counter=0. Buffer contents are not cleared.
- FSM states: IDLE, LOAD, UNPACK, DONE.
- IDLE:
  - in_ready=0.
  - start -> LOAD next cycle; clear the write pointer, and clear done if it was set.
- LOAD:
  - in_ready=1, busy=1.
  - On in_valid && in_ready: latch in_data into the shift register, clear the unpack counter, go to UNPACK.
  - If in_valid is low, stay in LOAD indefinitely; no timeout.
- UNPACK:
  - in_ready=0, busy=1.
  - Each cycle: write shift_reg[PIX_W-1:0] to buf[wr_ptr], increment wr_ptr, shift the register right by PIX_W, increment the counter.
  - After the PIX_PER_WORD-th write: go to DONE if wr_ptr has reached IMG_PIXELS, otherwise go to LOAD.
- DONE:
  - done=1, busy=0, in_ready=0.
  - start -> LOAD, same actions as from IDLE.
- Throughput: 1 accept cycle + PIX_PER_WORD unpack cycles per word, i.e. 9 cycles per word.
  - Default frame with in_valid held high: done rises 18 cycles after the first accept cycle.
- start is ignored while busy=1; it does not restart the frame.
- in_data/in_valid are ignored whenever in_ready=0. No word is lost or duplicated.
- Pointer wrap:
  - wr_ptr never exceeds IMG_PIXELS-1 for writes.
  - The completion check uses a wr_ptr+1 comparison, so ADDR_W overflow at power-of-two sizes is harmless.
- Read port:
  - rd_data = buf[rd_addr], registered, 1-cycle latency, usable in every state.
  - A read of the address being written in the same cycle returns the old value.
  - rd_addr >= IMG_PIXELS returns 0.
- Reset during LOAD or UNPACK: abort immediately, go to IDLE, partial buffer contents retained, done=0.
- rst and start in the same cycle: rst wins.

Optional Feature:
- Macro: WRITE_IMAGE_CHECKSUM_EN.
- When defined:
  - Adds output port checksum [15:0].
  - checksum accumulates the sum of every pixel written, modulo 2^16. Pixels are zero-extended.
  - Cleared to 0 on reset and on an accepted start; frozen while in DONE.
  - Its final value is valid in the same cycle done rises.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Basic frame:
  - Stimulus: reset, start, then in_valid held high with words 64'h0706050403020100 and 64'h0F0E0D0C0B0A0908.
  - Required: rd_addr 0..15 returns 0x00..0x0F; done rises exactly 18 cycles after the first accept; checksum (if enabled) = 0x0078.
- Backpressure gap:
  - Stimulus: in_valid low for 5 cycles between the two words.
  - Required: in_ready stays high through the gap; contents are identical to the basic frame; done is delayed by exactly 5 cycles.
- Ignored inputs:
  - Stimulus: pulse start during UNPACK of word 0; drive in_valid=1 with 64'hFFFFFFFFFFFFFFFF while in_ready=0.
  - Required: no restart, the FF word is not written, final buffer matches the basic frame.
- Reset mid-frame:
  - Stimulus: assert rst after 3 pixels of word 1 (buf[8..10] written).
  - Required: next cycle state is IDLE, busy=0, done=0; buf[0..10] retain their values. A following full frame of 64'hAAAA… words sets all 16 entries to 0xAA and done=1.
- Restart from DONE:
  - Stimulus: after a completed frame, start, then words of all 0x11 and all 0x22.
  - Required: done drops the cycle after start; buf[0..7]=0x11, buf[8..15]=0x22; checksum = 0x0198.
- Read edge cases:
  - Stimulus: read the address being written in the same cycle; read rd_addr beyond IMG_PIXELS using a parameter override IMG_PIXELS=8, ADDR_W=4 with rd_addr=12.
  - Required: the same-cycle read returns the old value; rd_addr=12 returns 0.
